sfft_butterfly_sequencer: RTL and testbench

Control stage that sits directly upstream of the SFFT pipeline buffer RAM and the twiddle (k-value) ROM. It walks every radix-2 butterfly of every FFT stage. Each cycle it issues the A/B read addresses for the buffer and the ROM index for the twiddle factor. It then replays the same A/B addresses as write addresses, with write enable, once the butterfly datapath has finished computing. It owns stage ordering, inter-stage hazards and the start/done handshake for one transform.

---
 rtl/sfft_butterfly_sequencer_if.sv | 34 +++
 rtl/sfft_butterfly_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_sfft_butterfly_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/sfft_butterfly_sequencer_if.sv
// Bundle between the SFFT butterfly sequencer, the pipeline buffer RAM and the twiddle ROM.
interface sfft_butterfly_sequencer_if #(
  parameter int NFFT = 256,
  parameter int nFFT = 8
);
  localparam int K_W = $clog2(nFFT * NFFT / 2);
  localparam int S_W = $clog2(nFFT);

  logic            start;
  logic            busy;
  logic            done;
  logic            readValid;
  logic [nFFT-1:0] readAddr_A;
  logic [nFFT-1:0] readAddr_B;
  logic [K_W-1:0]  kAddress;
  logic [S_W-1:0]  stageIndex;
  logic            writeEnable;
  logic [nFFT-1:0] writeAddr_A;
  logic [nFFT-1:0] writeAddr_B;
  logic            readBank;
  logic            writeBank;

  modport master (
    input  start,
    output busy, done, readValid, readAddr_A, readAddr_B, kAddress, stageIndex,
    output writeEnable, writeAddr_A, writeAddr_B, readBank, writeBank
  );

  modport slave (
    output start,
    input  busy, done, readValid, readAddr_A, readAddr_B, kAddress, stageIndex,
    input  writeEnable, writeAddr_A, writeAddr_B, readBank, writeBank
  );
endinterface

// File: rtl/sfft_butterfly_sequencer.sv
// Walks every radix-2 butterfly of every stage, issuing buffer/twiddle reads and delayed write-backs.
// Optional feature: SFFT_PINGPONG_EN (two buffer banks, stages run back-to-back without a drain).
//
// state | meaning
// IDLE  | waiting for start, counters cleared
// RUN   | one butterfly read issued per cycle
// DRAIN | reads paused until in-flight butterflies are written back
// DONE  | one-cycle done pulse
module sfft_butterfly_sequencer #(
  parameter int NFFT              = 256,
  parameter int nFFT              = 8,
  parameter int BUTTERFLY_LATENCY = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  sfft_butterfly_sequencer_if.master    bus
);

`ifdef SFFT_PINGPONG_EN
  localparam bit PINGPONG = 1'b1;
`else
  localparam bit PINGPONG = 1'b0;
`endif

  localparam int HALF = NFFT / 2;
  localparam int B_W  = nFFT - 1;
  localparam int S_W  = $clog2(nFFT);
  localparam int K_W  = $clog2(nFFT * NFFT / 2);
  localparam int L    = BUTTERFLY_LATENCY;
  localparam int D_W  = $clog2(L + 1);

  localparam logic [B_W-1:0] B_LAST = B_W'(HALF - 1);
  localparam logic [S_W-1:0] S_LAST = S_W'(nFFT - 1);
  localparam logic [D_W-1:0] D_LOAD = D_W'(L - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state, state_nxt;
  logic [S_W-1:0]  stage, stage_nxt;
  logic [B_W-1:0]  bfly, bfly_nxt;
  logic [D_W-1:0]  drain_cnt, drain_nxt;

  logic            rd_valid_nxt;
  logic [nFFT-1:0] b_ext, half, addr_a_nxt, addr_b_nxt;
  logic [S_W:0]    shift_up;
  logic [K_W-1:0]  k_nxt;

  logic            rd_valid;
  logic [nFFT-1:0] rd_a, rd_b;
  logic [K_W-1:0]  rd_k;
  logic [S_W-1:0]  rd_stage;
  logic            read_bank;

  logic            dl_valid [L];
  logic [nFFT-1:0] dl_a     [L];
  logic [nFFT-1:0] dl_b     [L];
  logic            dl_bank  [L];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      stage     <= '0;
      bfly      <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      stage     <= stage_nxt;
      bfly      <= bfly_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    stage_nxt = stage;
    bfly_nxt  = bfly;
    drain_nxt = drain_cnt;
    case (state)
      IDLE: begin
        stage_nxt = '0;
        bfly_nxt  = '0;
        if (bus.start) state_nxt = RUN;
      end
      RUN: begin
        if (bfly == B_LAST) begin
          bfly_nxt = '0;
          if (PINGPONG && stage != S_LAST) begin
            stage_nxt = stage + S_W'(1);
          end else begin
            state_nxt = DRAIN;
            drain_nxt = D_LOAD;
          end
        end else begin
          bfly_nxt = bfly + B_W'(1);
        end
      end
      DRAIN: begin
        if (drain_cnt == '0) begin
          if (stage == S_LAST) begin
            state_nxt = DONE;
          end else begin
            state_nxt = RUN;
            stage_nxt = stage + S_W'(1);
          end
        end else begin
          drain_nxt = drain_cnt - D_W'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read addresses are computed from the next butterfly so they register alongside readValid.
  always_comb begin
    bus.busy     = (state != IDLE);
    bus.done     = (state == DONE);
    rd_valid_nxt = (state_nxt == RUN);
    b_ext        = {1'b0, bfly_nxt};
    half         = nFFT'(1) << stage_nxt;
    shift_up     = {1'b0, stage_nxt} + (S_W + 1)'(1);
    addr_a_nxt   = ((b_ext >> stage_nxt) << shift_up) + (b_ext & (half - nFFT'(1)));
    addr_b_nxt   = addr_a_nxt + half;
    k_nxt        = K_W'(stage_nxt) * K_W'(HALF) + K_W'(bfly_nxt);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_a     <= '0;
      rd_b     <= '0;
      rd_k     <= '0;
      rd_stage <= '0;
    end else begin
      rd_valid <= rd_valid_nxt;
      if (rd_valid_nxt) begin
        rd_a     <= addr_a_nxt;
        rd_b     <= addr_b_nxt;
        rd_k     <= k_nxt;
        rd_stage <= stage_nxt;
      end
    end
  end

  assign read_bank = PINGPONG ? rd_stage[0] : 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < L; i++) begin
        dl_valid[i] <= 1'b0;
        dl_a[i]     <= '0;
        dl_b[i]     <= '0;
        dl_bank[i]  <= 1'b0;
      end
    end else begin
      dl_valid[0] <= rd_valid;
      dl_a[0]     <= rd_a;
      dl_b[0]     <= rd_b;
      dl_bank[0]  <= PINGPONG ? ~read_bank : 1'b0;
      for (int i = 1; i < L; i++) begin
        dl_valid[i] <= dl_valid[i-1];
        dl_a[i]     <= dl_a[i-1];
        dl_b[i]     <= dl_b[i-1];
        dl_bank[i]  <= dl_bank[i-1];
      end
    end
  end

  assign bus.readValid   = rd_valid;
  assign bus.readAddr_A  = rd_a;
  assign bus.readAddr_B  = rd_b;
  assign bus.kAddress    = rd_k;
  assign bus.stageIndex  = rd_stage;
  assign bus.readBank    = read_bank;
  assign bus.writeEnable = dl_valid[L-1];
  assign bus.writeAddr_A = dl_a[L-1];
  assign bus.writeAddr_B = dl_b[L-1];
  assign bus.writeBank   = dl_bank[L-1];

endmodule

// File: tb/tb_sfft_butterfly_sequencer.sv
// Directed bench for sfft_butterfly_sequencer at NFFT=8, nFFT=3, BUTTERFLY_LATENCY=2.
module tb_sfft_butterfly_sequencer;

`ifdef SFFT_PINGPONG_EN
  localparam bit PP       = 1'b1;
  localparam int DONE_OFS = 15;
`else
  localparam bit PP       = 1'b0;
  localparam int DONE_OFS = 19;
`endif

  localparam int EXP_A [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  localparam int EXP_B [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic [31:0] rd_val [$];
  int          rd_cyc [$];
  logic [31:0] wr_val [$];
  int          wr_cyc [$];
  int          done_cyc [$];

  sfft_butterfly_sequencer_if #(.NFFT(8), .nFFT(3)) bus ();

  sfft_butterfly_sequencer #(
    .NFFT(8), .nFFT(3), .BUTTERFLY_LATENCY(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.readValid) begin
      rd_cyc.push_back(cyc);
      rd_val.push_back({4'(bus.stageIndex), 4'(bus.readBank), 8'(bus.readAddr_A),
                        8'(bus.readAddr_B), 8'(bus.kAddress)});
    end
    if (bus.writeEnable) begin
      wr_cyc.push_back(cyc);
      wr_val.push_back({8'd0, 8'(bus.writeBank), 8'(bus.writeAddr_A), 8'(bus.writeAddr_B)});
    end
    if (bus.done) done_cyc.push_back(cyc);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {8'd0, bus.busy, bus.done, bus.readValid, bus.readAddr_A, bus.readAddr_B,
            bus.kAddress, bus.stageIndex, bus.writeEnable, bus.writeAddr_A,
            bus.writeAddr_B, bus.readBank, bus.writeBank};
  endfunction

  function automatic logic [31:0] exp_rd(input int i);
    int st = i / 4;
    return {4'(st), 4'(PP ? st % 2 : 0), 8'(EXP_A[i]), 8'(EXP_B[i]), 8'(i)};
  endfunction

  function automatic logic [31:0] exp_wr(input int i);
    int st = i / 4;
    return {8'd0, 8'(PP ? 1 - (st % 2) : 0), 8'(EXP_A[i]), 8'(EXP_B[i])};
  endfunction

  function automatic int exp_ofs(input int i);
    return 1 + i + (PP ? 0 : 2 * (i / 4));
  endfunction

  task automatic clear_log();
    rd_val.delete(); rd_cyc.delete();
    wr_val.delete(); wr_cyc.delete();
    done_cyc.delete();
  endtask

  task automatic check_transform(input int t0, input int r0, input int d0);
    for (int i = 0; i < 12; i++) begin
      if (r0 + i < rd_val.size()) begin
        check_val($sformatf("rd%0d", r0 + i), rd_val[r0+i], exp_rd(i));
        check_val($sformatf("rd_cyc%0d", r0 + i), rd_cyc[r0+i] - t0, exp_ofs(i));
      end
      if (r0 + i < wr_val.size()) begin
        check_val($sformatf("wr%0d", r0 + i), wr_val[r0+i], exp_wr(i));
        check_val($sformatf("wr_cyc%0d", r0 + i), wr_cyc[r0+i] - t0, exp_ofs(i) + 2);
      end
    end
    if (d0 < done_cyc.size())
      check_val($sformatf("done_cyc%0d", d0), done_cyc[d0] - t0, DONE_OFS);
  endtask

  // One start pulse; optionally a second pulse restart_ofs cycles later (must be ignored).
  task automatic do_transform(input string name, input int restart_ofs);
    int t0;
    bit seen = 1'b0;
    clear_log();
    @(negedge clk); #1;
    bus.start = 1'b1;
    t0 = cyc;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk); #1;
      bus.start = ((cyc - t0) == restart_ofs);
      if (done_cyc.size() != 0) seen = 1'b1;
    end
    bus.start = 1'b0;
    check_val({name, "_done_seen"}, 32'(seen), 32'd1);
    repeat (6) @(negedge clk);
    #1;
    check_val({name, "_reads"}, rd_val.size(), 12);
    check_val({name, "_writes"}, wr_val.size(), 12);
    check_val({name, "_dones"}, done_cyc.size(), 1);
    check_val({name, "_busy_after"}, 32'(bus.busy), 32'd0);
    check_transform(t0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, d, nrd, nwr;
    bit seen;
    reset     = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_val("reset_outs", all_outs(), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      check_val($sformatf("idle_outs%0d", i), all_outs(), 32'd0);
    end

    do_transform("basic", 0);
    do_transform("restart_mid", 5);

    // start held high: second transform only from IDLE after DONE
    clear_log();
    @(negedge clk); #1;
    bus.start = 1'b1;
    t0 = cyc;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk); #1;
      if (done_cyc.size() != 0) seen = 1'b1;
    end
    check_val("hold_done_seen", 32'(seen), 32'd1);
    d = seen ? done_cyc[0] : cyc;
    check_val("hold_reads_first", rd_val.size(), 12);
    @(negedge clk); #1;
    @(negedge clk); #1;
    bus.start = 1'b0;
    check_val("hold_restart_ofs", rd_cyc.size() > 12 ? rd_cyc[12] - d : -1, 32'd2);
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk); #1;
      if (done_cyc.size() > 1) seen = 1'b1;
    end
    repeat (6) @(negedge clk);
    #1;
    check_val("hold_reads", rd_val.size(), 24);
    check_val("hold_writes", wr_val.size(), 24);
    check_val("hold_dones", done_cyc.size(), 2);
    check_transform(t0, 0, 0);
    check_transform(d + 1, 12, 1);

    // asynchronous reset at the 6th read
    clear_log();
    @(negedge clk); #1;
    bus.start = 1'b1;
    @(negedge clk); #1;
    bus.start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      if (rd_val.size() >= 6) seen = 1'b1;
      else begin
        @(negedge clk); #1;
      end
    end
    check_val("rst_sixth_read", 32'(seen), 32'd1);
    reset = 1'b1;
    #1;
    check_val("rst_async_outs", all_outs(), 32'd0);
    nrd = rd_val.size();
    nwr = wr_val.size();
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    check_val("rst_no_reads", rd_val.size() - nrd, 0);
    check_val("rst_no_writes", wr_val.size() - nwr, 0);
    check_val("rst_idle_outs", all_outs(), 32'd0);

    do_transform("post_reset", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
